tail_light_seq: RTL and testbench

- Parametrised sequential tail-light controller for N lamps per side, with turn, hazard and brake modes.
- Adds dim running lights through an internal PWM. The PWM is derived from clk, so no separate dim clock is needed.
- Drives the lamp vector directly and sits between the driver-input synchroniser and the lamp drivers.

---
 rtl/tail_light_pkg.sv | 14 +
 rtl/tl_step_timer.sv | 33 +++
 rtl/tail_light_seq.sv | 133 +++++++++++++
 tb/tb_tail_light_seq.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/tail_light_pkg.sv
// Shared types for the tail-light sequencer: operating modes, lamp drive levels, flash length.
// Pure definitions, no clocked logic and no flow control.
package tail_light_pkg;

  typedef enum logic [1:0] {IDLE, TURN_L, TURN_R, HAZ} mode_e;
  typedef enum logic [1:0] {OFF, DIM, FULL} lvl_e;

  localparam int FLASH_COUNT = 3;

  function automatic logic lvl_on(input lvl_e lvl, input logic dim_on);
    return (lvl == FULL) || ((lvl == DIM) && dim_on);
  endfunction

endpackage

// File: rtl/tl_step_timer.sv
// Sequence step divider: counts 0..STEP_DIV-1 and flags the last count as tick_o.
// Tick is combinational from the count; clr_i restarts the count and always accepts.
module tl_step_timer #(
  parameter int STEP_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CW'(STEP_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tail_light_seq.sv
// Sequential tail lights (turn/hazard/brake, PWM-dimmed running lights); led is registered, 1 clk latency, no backpressure.
// Defining TAIL_LIGHT_BRAKE_FLASH_EN adds a brake-onset flash burst of 2*FLASH_COUNT step ticks.
module tail_light_seq
  import tail_light_pkg::*;
#(
  parameter int LEDS_PER_SIDE = 3,
  parameter int STEP_DIV      = 4,
  parameter int PWM_BITS      = 4,
  parameter int DIM_DUTY      = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       left,
  input  logic                       right,
  input  logic                       hazard,
  input  logic                       brake,
  input  logic                       ctrl,
  output logic [2*LEDS_PER_SIDE-1:0] led
);

  localparam int N  = LEDS_PER_SIDE;
  localparam int PW = $clog2(N + 1);

  mode_e               mode_q, mode_d;
  logic [PW-1:0]       phase_q, phase_d;
  logic [PWM_BITS-1:0] pwm_q;
  logic [2*N-1:0]      led_q, led_d;
  logic                mode_chg, tick, dim_on, brake_lit;
  logic                seq_l, seq_r;
  lvl_e                base_lvl, turn_lvl, l_unlit, r_unlit;

  tl_step_timer #(.STEP_DIV(STEP_DIV)) u_step (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (mode_chg),
    .tick_o (tick)
  );

  always_comb begin
    mode_d = IDLE;
    if (hazard || (left && right)) begin
      mode_d = HAZ;
    end else if (left) begin
      mode_d = TURN_L;
    end else if (right) begin
      mode_d = TURN_R;
    end
  end

  assign mode_chg = (mode_d != mode_q);

  // A mode change wins over a coincident tick so every new mode starts dark.
  always_comb begin
    phase_d = phase_q;
    if (mode_chg || (mode_q == IDLE)) begin
      phase_d = '0;
    end else if (tick) begin
      phase_d = (phase_q == PW'(N)) ? '0 : phase_q + PW'(1);
    end
  end

  assign dim_on = (pwm_q < PWM_BITS'(DIM_DUTY));

`ifdef TAIL_LIGHT_BRAKE_FLASH_EN
  localparam int FCW = $clog2(2 * FLASH_COUNT);

  logic           brake_prev_q, flash_act_q, flash_on_q;
  logic [FCW-1:0] flash_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      brake_prev_q <= 1'b0;
      flash_act_q  <= 1'b0;
      flash_on_q   <= 1'b1;
      flash_cnt_q  <= '0;
    end else begin
      brake_prev_q <= brake;
      if (!brake) begin
        flash_act_q <= 1'b0;
        flash_on_q  <= 1'b1;
      end else if (!brake_prev_q) begin
        flash_act_q <= 1'b1;
        flash_on_q  <= 1'b1;
        flash_cnt_q <= '0;
      end else if (flash_act_q && tick) begin
        if (flash_cnt_q == FCW'(2 * FLASH_COUNT - 1)) begin
          flash_act_q <= 1'b0;
          flash_on_q  <= 1'b1;
        end else begin
          flash_cnt_q <= flash_cnt_q + FCW'(1);
          flash_on_q  <= ~flash_on_q;
        end
      end
    end
  end

  assign brake_lit = brake && (!flash_act_q || flash_on_q);
`else
  assign brake_lit = brake;
`endif

  // Brake never lights a turning side's dark lamps; hazard dark lamps still show brake.
  always_comb begin
    base_lvl = brake_lit ? FULL : (ctrl ? DIM : OFF);
    turn_lvl = ctrl ? DIM : OFF;
    seq_l    = (mode_q == TURN_L) || (mode_q == HAZ);
    seq_r    = (mode_q == TURN_R) || (mode_q == HAZ);
    l_unlit  = (mode_q == TURN_L) ? turn_lvl : base_lvl;
    r_unlit  = (mode_q == TURN_R) ? turn_lvl : base_lvl;
    led_d    = '0;
    for (int k = 0; k < N; k++) begin
      led_d[N-1-k] = (seq_r && (PW'(k) < phase_q)) || lvl_on(r_unlit, dim_on);
      led_d[N+k]   = (seq_l && (PW'(k) < phase_q)) || lvl_on(l_unlit, dim_on);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q  <= IDLE;
      phase_q <= '0;
      pwm_q   <= '0;
      led_q   <= '0;
    end else begin
      mode_q  <= mode_d;
      phase_q <= phase_d;
      pwm_q   <= pwm_q + PWM_BITS'(1);
      led_q   <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_tail_light_seq.sv
// Scoreboard bench for tail_light_seq in its default build (brake flash disabled).
module tb_tail_light_seq;
  import tail_light_pkg::*;

  localparam int N  = 3;
  localparam int SD = 4;
  localparam int PB = 4;
  localparam int DD = 3;

  logic       clk = 1'b0;
  logic       reset, left, right, hazard, brake, ctrl;
  logic [5:0] led, led0, last_led;

  int total = 0;
  int bad   = 0;

  logic [5:0] exp_q[$];

  mode_e m_mode;
  int    m_t;
  int    m_pwm;

  always #5 clk = ~clk;

  tail_light_seq #(
    .LEDS_PER_SIDE(N), .STEP_DIV(SD), .PWM_BITS(PB), .DIM_DUTY(DD)
  ) dut (
    .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard),
    .brake(brake), .ctrl(ctrl), .led(led)
  );

  tail_light_seq #(
    .LEDS_PER_SIDE(N), .STEP_DIV(SD), .PWM_BITS(PB), .DIM_DUTY(0)
  ) dut0 (
    .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard),
    .brake(brake), .ctrl(ctrl), .led(led0)
  );

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", tag, got, want, $time);
    end
  endtask

  // Reference: phase follows from cycles spent in the current mode.
  function automatic logic [5:0] model_led();
    int         ph;
    logic       dim, base_on, turn_on;
    logic [5:0] r;
    ph      = (m_mode == IDLE) ? 0 : (m_t / SD) % (N + 1);
    dim     = (m_pwm < DD);
    base_on = brake || (ctrl && dim);
    turn_on = ctrl && dim;
    r       = '0;
    for (int k = 0; k < N; k++) begin
      case (m_mode)
        TURN_R: begin
          r[N-1-k] = (k < ph) || turn_on;
          r[N+k]   = base_on;
        end
        TURN_L: begin
          r[N-1-k] = base_on;
          r[N+k]   = (k < ph) || turn_on;
        end
        HAZ: begin
          r[N-1-k] = (k < ph) || base_on;
          r[N+k]   = (k < ph) || base_on;
        end
        default: begin
          r[N-1-k] = base_on;
          r[N+k]   = base_on;
        end
      endcase
    end
    return r;
  endfunction

  task automatic cycle();
    mode_e nm;
    if (reset) exp_q.push_back(6'b000000);
    else       exp_q.push_back(model_led());
    if (hazard || (left && right)) nm = HAZ;
    else if (left)                 nm = TURN_L;
    else if (right)                nm = TURN_R;
    else                           nm = IDLE;
    if (reset) begin
      m_mode = IDLE;
      m_t    = 0;
      m_pwm  = 0;
    end else begin
      if (nm != m_mode) begin
        m_mode = nm;
        m_t    = 0;
      end else begin
        m_t++;
      end
      m_pwm = (m_pwm + 1) % (1 << PB);
    end
    @(posedge clk);
    @(negedge clk);
    last_led = led;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_empty: got %b want queued value", led);
    end else begin
      check("sb", led, exp_q.pop_front());
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int         ones[6];
    logic [5:0] led0_or;

    reset = 1'b1; left = 1'b0; right = 1'b0; hazard = 1'b0; brake = 1'b0; ctrl = 1'b0;
    m_mode = IDLE; m_t = 0; m_pwm = 0;
    @(negedge clk);
    cyc(2);
    check("reset", last_led, 6'b000000);
    reset = 1'b0;
    cyc(4);
    check("idle", last_led, 6'b000000);

    right = 1'b1;
    cyc(6);  check("r_p1", last_led, 6'b000100);
    cyc(4);  check("r_p2", last_led, 6'b000110);
    cyc(4);  check("r_p3", last_led, 6'b000111);
    cyc(4);  check("r_wrap", last_led, 6'b000000);
    cyc(8);  check("r_p2b", last_led, 6'b000110);

    hazard = 1'b1;
    cyc(2);  check("haz_dark", last_led, 6'b000000);
    cyc(4);  check("haz_p1", last_led, 6'b001100);
    cyc(4);  check("haz_p2", last_led, 6'b011110);
    cyc(4);  check("haz_p3", last_led, 6'b111111);

    hazard = 1'b0; right = 1'b0;
    cyc(3);  check("back_idle", last_led, 6'b000000);

    left = 1'b1; brake = 1'b1;
    cyc(2);  check("lb_p0", last_led, 6'b000111);
    cyc(4);  check("lb_p1", last_led, 6'b001111);
    cyc(4);  check("lb_p2", last_led, 6'b011111);
    cyc(4);  check("lb_p3", last_led, 6'b111111);

    left = 1'b0; brake = 1'b0; ctrl = 1'b1;
    cyc(3);
    for (int b = 0; b < 6; b++) ones[b] = 0;
    led0_or = '0;
    for (int i = 0; i < 32; i++) begin
      cycle();
      led0_or |= led0;
      for (int b = 0; b < 6; b++) ones[b] += int'(last_led[b]);
    end
    for (int b = 0; b < 6; b++) check($sformatf("dim_bit%0d", b), 6'(ones[b]), 6'd6);
    check("dim_duty0", led0_or, 6'b000000);

    for (int s = 0; s < 40; s++) begin
      left   = 1'($urandom_range(0, 1));
      right  = 1'($urandom_range(0, 1));
      hazard = ($urandom_range(0, 5) == 0);
      brake  = 1'($urandom_range(0, 1));
      ctrl   = 1'($urandom_range(0, 1));
      cyc($urandom_range(1, 14));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
